wb_regfile: RTL

- Consumer end of the MEM/WB pipeline register in the pipelined MIPS core.
- Takes the registered control bits, ALU result, memory load data and destination register index from MEM/WB.
- Selects the write-back value and commits it into a 32-entry general-purpose register file.
- Serves the two decode-stage read ports, with write-to-read bypass, and keeps a retired-write counter for debug and performance checks.

---
 rtl/wb_regfile.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and general-purpose register file of the pipelined MIPS
//   core. It takes the MEM/WB pipeline register outputs, selects the
//   write-back value, and commits that value into a 2**ADDR_W entry register
//   file. It also serves the two decode read ports and bypasses a same-cycle
//   write to those ports. A retired-write counter is kept for debug and
//   performance checks.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = in reset)
//   wb_sig     MEM/WB control: [1] RegWrite, [0] MemtoReg
//   wb_alu     ALU result from MEM/WB
//   wb_mem     load data from MEM/WB
//   wb_rd      destination register index from MEM/WB
//   ra1, ra2   decode read indices (rs, rt)
//   rd1, rd2   decode read data (r0 reads 0, same-cycle write bypassed)
//   wb_data    selected write-back value (driven whatever RegWrite is)
//   wb_we      effective write enable: RegWrite and wb_rd != 0
//   retire_cnt number of edges with RegWrite=1 since reset, wraps silently
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_sig,
    input  logic [DATA_W-1:0] wb_alu,
    input  logic [DATA_W-1:0] wb_mem,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [CNT_W-1:0]  retire_cnt_d;

    // Write-back select and effective write enable
    always_comb begin
        wb_data = wb_sig[0] ? wb_mem : wb_alu;
        wb_we   = wb_sig[1] && (wb_rd != '0);
    end

    // Next-state for the register file. Entry 0 is forced to zero so it
    // never holds anything, even though wb_we already excludes it.
    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    // The counter tracks RegWrite, not wb_we, so writes aimed at r0 count too.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (wb_sig[1]) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q       <= '{default: '0};
            retire_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Read ports: the bypass lets decode see the MEM/WB write in the same
    // cycle, so no separate WB-to-ID forwarding path is needed. It is not
    // gated by rst, so it stays active while the array is held in reset.
    always_comb begin
        rd1 = regs_q[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (wb_we && (ra1 == wb_rd)) begin
            rd1 = wb_data;
        end
    end

    always_comb begin
        rd2 = regs_q[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (wb_we && (ra2 == wb_rd)) begin
            rd2 = wb_data;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule
